// File: rtl/spi_slave_responder_if.sv
// spi_slave_responder_if: local-side TX/RX word exchange bundle for the SPI responder
interface spi_slave_responder_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] tx_data_i;
  logic              tx_valid_i;
  logic              tx_ready_o;
  logic [DATA_W-1:0] rx_data_o;
  logic              rx_valid_o;
  logic              tx_underrun_o;
  logic              busy_o;
  modport slave (
    input  tx_data_i, tx_valid_i,
    output tx_ready_o, rx_data_o, rx_valid_o, tx_underrun_o, busy_o
  );
  modport master (
    output tx_data_i, tx_valid_i,
    input  tx_ready_o, rx_data_o, rx_valid_o, tx_underrun_o, busy_o
  );
endinterface

// File: rtl/spi_slave_responder.sv
// spi_slave_responder: mode-0 SPI responder, oversampled inputs, valid/ready TX and pulsed RX
module spi_slave_responder #(
  parameter int                DATA_W      = 8,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] TX_IDLE     = '0
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic spi_clk_i,
  input  logic spi_mosi_i,
  input  logic spi_cs_i,
  output logic spi_miso_o,
  spi_slave_responder_if.slave bus
);
  localparam int CW = $clog2(DATA_W);
  typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sclk_s, mosi_s, cs_s;
  logic sclk_d, sclk_q, mosi_q, cs_q;
  logic rise, fall, accept, load, last, reload;
  logic [DATA_W-1:0] hold_data, tx_sr, load_word, rx_next;
  logic [DATA_W-2:0] rx_sr;
  logic [CW-1:0] bit_cnt;
  assign sclk_q = sclk_s[SYNC_STAGES-1];
  assign mosi_q = mosi_s[SYNC_STAGES-1];
  assign cs_q = cs_s[SYNC_STAGES-1];
  assign spi_miso_o = bus.busy_o & tx_sr[DATA_W-1];
  // CS resets to "selected" so a frame already running at reset release is skipped
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      sclk_s <= '0;
      mosi_s <= '0;
      cs_s <= '0;
      sclk_d <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[SYNC_STAGES-2:0], spi_clk_i};
      mosi_s <= {mosi_s[SYNC_STAGES-2:0], spi_mosi_i};
      cs_s <= {cs_s[SYNC_STAGES-2:0], spi_cs_i};
      sclk_d <= sclk_q;
    end
  always_comb begin
    rise = sclk_q & ~sclk_d;
    fall = ~sclk_q & sclk_d;
    accept = bus.tx_valid_i & bus.tx_ready_o;
    load = ~cs_q & ((state == IDLE) | ((state == ACTIVE) & fall & reload));
    load_word = bus.tx_ready_o ? TX_IDLE : hold_data;
    rx_next = {rx_sr, mosi_q};
    last = bit_cnt == CW'(DATA_W - 1);
  end
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      state <= WAIT_IDLE;
      bus.tx_ready_o <= 1'b1;
      bus.rx_data_o <= '0;
      bus.rx_valid_o <= 1'b0;
      bus.tx_underrun_o <= 1'b0;
      bus.busy_o <= 1'b0;
      hold_data <= '0;
      tx_sr <= '0;
      rx_sr <= '0;
      bit_cnt <= '0;
      reload <= 1'b0;
    end else begin
      bus.rx_valid_o <= 1'b0;
      bus.tx_underrun_o <= load & bus.tx_ready_o;
      if (accept) hold_data <= bus.tx_data_i;
      // a write into an empty holding reg wins over a same-cycle load from it
      bus.tx_ready_o <= accept ? 1'b0 : (load | bus.tx_ready_o);
      if (load) tx_sr <= load_word;
      case (state)
        WAIT_IDLE: if (cs_q) state <= IDLE;
        IDLE: if (!cs_q) begin
          state <= ACTIVE;
          bus.busy_o <= 1'b1;
          bit_cnt <= '0;
          reload <= 1'b0;
        end
        ACTIVE: if (cs_q) begin
          state <= IDLE;
          bus.busy_o <= 1'b0;
          bit_cnt <= '0;
          reload <= 1'b0;
        end else if (rise) begin
          rx_sr <= rx_next[DATA_W-2:0];
          bit_cnt <= last ? '0 : bit_cnt + 1'b1;
          if (last) begin
            bus.rx_data_o <= rx_next;
            bus.rx_valid_o <= 1'b1;
            reload <= 1'b1;
          end
        end else if (fall) begin
          if (reload) reload <= 1'b0;
          else tx_sr <= tx_sr << 1;
        end
        default: state <= WAIT_IDLE;
      endcase
    end
endmodule
